pe_inst_seq: RTL

- Synthesizable instruction sequencer that drives a parallel_pe-class dot-product engine.
- Reads a small instruction table in which each entry is an iteration length.
- Streams shared neuron/weight read addresses with pe_ctl first/last markers and a valid strobe, honouring an upstream stall.
- Collects PE results into a result buffer write port and signals completion with a start/busy/done handshake.

---
 rtl/pe_inst_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pe_inst_seq.sv
// Instruction sequencer: walks a length table and streams shared operand addresses to a dot-product PE.
// Latency: first beat 2 cycles after start, one bubble between instructions, done 1 cycle after the last result lands.
// Backpressure: stall holds rd_addr/iter and suppresses pe_vld_i; PE results are always accepted while busy.
module pe_inst_seq #(
    parameter int INST_NUM = 4,
    parameter int ITER_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int RES_W    = 32,
    parameter int INST_AW  = $clog2(INST_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [INST_AW:0]   inst_count,
    output logic [INST_AW-1:0] inst_rd_addr,
    input  logic [ITER_W-1:0]  inst_rd_data,
    input  logic               stall,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               pe_vld_i,
    output logic [1:0]         pe_ctl,
    input  logic [RES_W-1:0]   pe_result,
    input  logic               pe_vld_o,
    output logic               res_wr_en,
    output logic [INST_AW-1:0] res_wr_addr,
    output logic [RES_W-1:0]   res_wr_data,
    output logic               busy,
    output logic               done,
    output logic               err_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [INST_AW:0]  NUM_L    = (INST_AW+1)'(INST_NUM);
    localparam logic [INST_AW:0]  CNT_ONE  = (INST_AW+1)'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_q;
    logic [INST_AW:0]    cnt_q;       // instructions in this run (already clamped)
    logic [INST_AW:0]    ptr_q;       // next table entry to fetch
    logic [INST_AW:0]    issued_q;    // instructions actually issued (zero-length ones excluded)
    logic [INST_AW:0]    res_cnt_q;   // results written so far
    logic [INST_AW:0]    res_cnt_d;
    logic [ITER_W-1:0]   len_q;
    logic [ITER_W-1:0]   iter_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                err_zero_q;

    logic                beat;
    logic                first_beat;
    logic                last_beat;
    logic                res_wr;

    // Beat qualification and result capture are combinational so stall takes effect the same cycle.
    always_comb begin
        beat       = (state_q == S_ISSUE) & ~stall;
        first_beat = beat & (iter_q == '0);
        last_beat  = beat & (iter_q == (len_q - ITER_ONE));
        res_wr     = pe_vld_o & (state_q != S_IDLE);
        res_cnt_d  = res_wr ? (res_cnt_q + CNT_ONE) : res_cnt_q;
    end

    assign inst_rd_addr = ptr_q[INST_AW-1:0];
    assign rd_addr      = rd_addr_q;
    assign pe_vld_i     = beat;
    assign pe_ctl       = {last_beat, first_beat};
    assign res_wr_en    = res_wr;
    assign res_wr_addr  = res_cnt_q[INST_AW-1:0];
    assign res_wr_data  = pe_result;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err_zero     = err_zero_q;

    // Sequencer FSM plus all run counters; reset aborts any run in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            issued_q   <= '0;
            res_cnt_q  <= '0;
            len_q      <= '0;
            iter_q     <= '0;
            rd_addr_q  <= '0;
            err_zero_q <= 1'b0;
        end else begin
            // Results can land in any busy state, including the bubble and drain cycles.
            res_cnt_q <= res_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q      <= (inst_count > NUM_L) ? NUM_L : inst_count;
                        rd_addr_q  <= base_addr;
                        ptr_q      <= '0;
                        issued_q   <= '0;
                        res_cnt_q  <= '0;
                        err_zero_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ptr_q == cnt_q) begin
                        state_q <= S_DRAIN;
                    end else if (inst_rd_data == '0) begin
                        // Zero-length entries take no beats and no result slot.
                        err_zero_q <= 1'b1;
                        ptr_q      <= ptr_q + CNT_ONE;
                    end else begin
                        len_q   <= inst_rd_data;
                        iter_q  <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (beat) begin
                        rd_addr_q <= rd_addr_q + ADDR_ONE;
                        iter_q    <= iter_q + ITER_ONE;
                    end
                    if (last_beat) begin
                        ptr_q    <= ptr_q + CNT_ONE;
                        issued_q <= issued_q + CNT_ONE;
                        state_q  <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Compare against the post-write count so a result landing now finishes the run.
                    if (res_cnt_d == issued_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
